// File: rtl/sync_down_counter_pkg.sv
// rtl/sync_down_counter_pkg.sv - shared types and constants for sync_down_counter
//
// Purpose: holds the FSM state encoding and the default counter width.
// Ports:   none (package).
package sync_down_counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_cnt_core.sv
// rtl/down_cnt_core.sv - loadable down-counter datapath register with reload mux
//
// Purpose: WIDTH-bit count register plus the reload register. On load both are
//          written with the load value. On a step the count either decrements or
//          is replaced by the reload value. Also provides the q==1 and
//          load_value==0 detects used by the control FSM.
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous, active-high reset
//   i_load         - load request (priority over step)
//   i_load_value   - start value
//   i_step         - advance the count this edge
//   i_reload       - with i_step, take the reload value instead of decrementing
//   o_q            - current count (registered)
//   o_q_is_one     - o_q == 1
//   o_load_is_zero - i_load_value == 0
import sync_down_counter_pkg::*;

module down_cnt_core #(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_step,
  input  logic             i_reload,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_is_one,
  output logic             o_load_is_zero
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_q      <= i_load_value;
      r_reload <= i_load_value;
    end else if (i_step) begin
      r_q <= i_reload ? r_reload : (r_q - WIDTH'(1));
    end
  end

  assign o_q            = r_q;
  assign o_q_is_one     = (r_q == WIDTH'(1));
  assign o_load_is_zero = (i_load_value == '0);

endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - synchronous loadable down counter with terminal count
//
// Purpose: programmable interval/timeout timer. Load a start value, count down on
//          enabled cycles while in RUN, pulse tc for one cycle on expiry.
//          Build option SYNC_DOWN_COUNTER_AUTO_RELOAD_EN: on expiry reload the
//          last loaded value and keep running (periodic timer). Undefined: one-shot.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset (highest priority)
//   load       - load request, priority over en
//   load_value - start value
//   en         - count enable, used only in RUN
//   q          - current count (registered)
//   busy       - state == RUN
//   done       - state == DONE (sticky until next load or reset)
//   tc         - one-cycle terminal-count pulse (registered)
import sync_down_counter_pkg::*;

module sync_down_counter #(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
  localparam logic AUTO_RELOAD = 1'b1;
`else
  localparam logic AUTO_RELOAD = 1'b0;
`endif

  state_t r_state;
  state_t w_state_next;
  logic   r_tc;
  logic   w_tc_next;
  logic   w_step;
  logic   w_expire;
  logic   w_q_is_one;
  logic   w_load_is_zero;

  // A step only happens in RUN without a competing load.
  assign w_step   = (r_state == RUN) && en && !load;
  // Expiry: the step that takes the count from 1 to 0 (or back to reload).
  assign w_expire = w_step && w_q_is_one;

  down_cnt_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk            (clk),
    .reset          (reset),
    .i_load         (load),
    .i_load_value   (load_value),
    .i_step         (w_step),
    .i_reload       (w_expire && AUTO_RELOAD),
    .o_q            (q),
    .o_q_is_one     (w_q_is_one),
    .o_load_is_zero (w_load_is_zero)
  );

  // State register and tc register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tc    <= w_tc_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_tc_next    = 1'b0;
    if (load) begin
      // A zero load expires immediately; a restart never pulses tc for the
      // aborted count.
      w_state_next = w_load_is_zero ? DONE : RUN;
      w_tc_next    = w_load_is_zero;
    end else begin
      case (r_state)
        IDLE: w_state_next = IDLE;
        RUN: begin
          if (w_expire) begin
            w_state_next = AUTO_RELOAD ? RUN : DONE;
            w_tc_next    = 1'b1;
          end
        end
        DONE:    w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
    tc   = r_tc;
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - directed self-checking bench for sync_down_counter
module tb_sync_down_counter;

  localparam int W = 65;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         en;
  logic [W-1:0] q;
  logic         busy;
  logic         done;
  logic         tc;

  int n_cmp = 0;
  int n_bad = 0;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .en         (en),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] eq, input logic eb,
                           input logic ed, input logic et);
    check({tag, ".q"}, q, eq);
    check({tag, ".busy"}, W'(busy), W'(eb));
    check({tag, ".done"}, W'(done), W'(ed));
    check({tag, ".tc"}, W'(tc), W'(et));
  endtask

  logic [W-1:0] all_ones;

  initial begin
    all_ones = '1;
    reset = 1'b1; load = 1'b1; load_value = W'(5); en = 1'b0;
    #2;
    // Reset wins over a simultaneous load.
    tick();
    check_out("rst", '0, 1'b0, 1'b0, 1'b0);

    // IDLE ignores en.
    reset = 1'b0; load = 1'b0; en = 1'b1;
    tick();
    check_out("idle_en", '0, 1'b0, 1'b0, 1'b0);

    // Load 5, continuous enable: 5,4,3,2,1,0 with tc at q==0.
    load = 1'b1; load_value = W'(5); en = 1'b1;
    tick();
    check_out("l5_k0", W'(5), 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 5)       check_out($sformatf("l5_k%0d", k), W'(5 - k), 1'b1, 1'b0, 1'b0);
      else if (k == 5) check_out("l5_k5", '0, 1'b0, 1'b1, 1'b1);
      else             check_out("l5_k6", '0, 1'b0, 1'b1, 1'b0);
    end

    // Load 4, en toggling (1 on the load edge, then 0,1,0,...): tc 8 cycles later.
    load = 1'b1; load_value = W'(4); en = 1'b1;
    tick();
    check_out("tg_k0", W'(4), 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      en = (k % 2 == 0);
      tick();
      if (k < 8)       check_out($sformatf("tg_k%0d", k), W'(4 - k / 2), 1'b1, 1'b0, 1'b0);
      else if (k == 8) check_out("tg_k8", '0, 1'b0, 1'b1, 1'b1);
      else             check_out("tg_k9", '0, 1'b0, 1'b1, 1'b0);
    end

    // Restart mid-count at q=3 with 10: no tc, countdown restarts.
    load = 1'b1; load_value = W'(5); en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    check_out("rs_q3", W'(3), 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_value = W'(10);
    tick();
    check_out("rs_q10", W'(10), 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    check_out("rs_q9", W'(9), 1'b1, 1'b0, 1'b0);

    // Load of 0: immediate expiry, single tc.
    load = 1'b1; load_value = '0;
    tick();
    check_out("z_k0", '0, 1'b0, 1'b1, 1'b1);
    load = 1'b0;
    tick();
    check_out("z_k1", '0, 1'b0, 1'b1, 1'b0);

    // Load 1 from DONE.
    load = 1'b1; load_value = W'(1); en = 1'b1;
    tick();
    check_out("one_k0", W'(1), 1'b1, 1'b0, 1'b0);
    load = 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_out($sformatf("one_k%0d", k), W'(1), 1'b1, 1'b0, 1'b1);
    end
    // Periodic: load 3, 12 enabled cycles -> 2,1,3,2,1,3,... tc on each reload.
    load = 1'b1; load_value = W'(3);
    tick();
    check_out("ar_k0", W'(3), 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_out($sformatf("ar_k%0d", k), W'(3 - (k % 3)), 1'b1, 1'b0, (k % 3 == 0));
    end
`else
    tick();
    check_out("one_k1", '0, 1'b0, 1'b1, 1'b1);
    tick();
    check_out("one_k2", '0, 1'b0, 1'b1, 1'b0);
`endif

    // Width boundary: all ones minus 3 after three steps.
    load = 1'b1; load_value = all_ones; en = 1'b1;
    tick();
    check_out("wb_k0", all_ones, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    tick();
    tick();
    check_out("wb_k3", all_ones - W'(3), 1'b1, 1'b0, 1'b0);
    // Reset mid-count.
    reset = 1'b1;
    tick();
    check_out("wb_rst", '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; en = 1'b0;
    tick();
    check_out("wb_idle", '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, loadable down counter. It is the countdown counterpart to the team's ripple up-counter. A start value is loaded, the counter decrements on each enabled clock, and it signals terminal count when it reaches zero. All state is clocked on the single clock edge: no derived clocks and no ripple. It is used as a programmable interval/timeout timer beside the up-counter.

Parameters:
- WIDTH, 65, counter and load-value width in bits (matches the up-counter width).

Ports:
- clk, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- load, input, 1, load request; samples load_value on this clock edge.
- load_value, input, WIDTH, start value for the countdown.
- en, input, 1, count enable; only meaningful in RUN.
- q, output, WIDTH, current count value (registered).
- busy, output, 1, high while in RUN.
- done, output, 1, sticky expiry flag; high in DONE.
- tc, output, 1, one-cycle terminal-count pulse (registered).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset). Reset has priority over every other input.
- Reset values: q=0, state=IDLE, busy=0, done=0, tc=0, internal reload register=0.
- States:
  - IDLE: waits for load; en is ignored.
  - RUN: counting.
  - DONE: expired; q holds 0 and en is ignored.
- load, from any state:
  - q<=load_value and reload<=load_value on the same edge.
  - load_value!=0: next state RUN.
  - load_value==0: next state DONE, tc=1 for the following cycle (immediate expiry).
- load has priority over en. A load while in RUN restarts the countdown with the new value, with no tc for the aborted count.
- RUN with en=1 and no load:
  - q>1: q<=q-1.
  - q==1: q<=0, tc=1 on the next cycle (the cycle q reads 0), next state DONE.
- RUN with en=0: q holds and no tc.
- Latency: loading N and holding en=1 gives tc high exactly N cycles after the load edge.
- tc is high for exactly one cycle per expiry and is never high in consecutive cycles in one-shot mode.
- busy=(state==RUN); done=(state==DONE). Both are registered state decodes.
- Arithmetic: unsigned. q never decrements below 0 because the counter leaves RUN at zero, so there is no wrap-around.

Optional Feature:
- Macro: SYNC_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined: in RUN with en=1 and q==1, q<=reload, tc pulses, and the state stays RUN, giving a periodic timer with period = reload value.
  - reload==1 gives tc high on every enabled cycle.
  - DONE is entered only through a load of 0.
  - A load of 0 still goes to DONE.
- Undefined: one-shot behaviour as described above. The reload register may be optimised away.

Decomposition:
- Package sync_down_counter_pkg holds:
  - the state typedef (IDLE, RUN, DONE as a 2-bit enum);
  - the default width constant CNT_WIDTH_DEFAULT=65.
- One sub-module is natural: down_cnt_core, the WIDTH-bit datapath register with load, decrement, reload-mux and a zero/one detect.
- The FSM and tc register stay in the top module.

Test Plan:
- Reset asserted with load=1 and load_value=5 on the same edge -> q=0, state IDLE, busy=0, done=0, tc=0 (reset wins).
- load_value=5, then en=1 continuously -> q reads 5,4,3,2,1,0; tc high only in the cycle q=0 (5 cycles after load); done=1 from then on; busy low.
- load_value=4, en toggling 1,0,1,0,... -> q decrements only on enabled cycles; tc arrives 8 cycles after load.
- In RUN at q=3, assert load with load_value=10 -> q=10 next cycle, no tc pulse, countdown restarts; a separate load of 0 -> done=1 with a single tc pulse.
- With SYNC_DOWN_COUNTER_AUTO_RELOAD_EN, load 3 and en=1 for 12 cycles -> q cycles 3,2,1,3,2,1,...; tc pulses every 3 cycles; busy stays 1; done stays 0.
- Width boundary, WIDTH=65: load 2^65-1, run 3 cycles -> q=2^65-4 with no truncation; then reset mid-count -> q=0 and state IDLE on the next edge.
